// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one mem_data instance between NCORES cores.
// Define ARB_LOCK_EN to enable atomic lock sequences for read-modify-write.
module shared_mem_arbiter #(
    parameter int NCORES = 2,
    parameter int MDATAW = 6,
    parameter int NUBITS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NCORES-1:0]          req,
    input  logic [NCORES-1:0]          we,
    input  logic [NCORES*MDATAW-1:0]   addr,
    input  logic [NCORES*NUBITS-1:0]   wdata,
    input  logic [NCORES-1:0]          lock,
    output logic [NCORES-1:0]          gnt,
    output logic [NCORES-1:0]          rvalid,
    output logic [NUBITS-1:0]          rdata,
    output logic                       mem_wr,
    output logic [MDATAW-1:0]          mem_addr_w,
    output logic [MDATAW-1:0]          mem_addr_r,
    output logic [NUBITS-1:0]          mem_wdata,
    input  logic [NUBITS-1:0]          mem_rdata
);
    localparam int PTRW = (NCORES > 1) ? $clog2(NCORES) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [PTRW-1:0]   ptr_q, ptr_d;
    logic [PTRW-1:0]   owner_q, owner_d;
    logic [0:0]        state_q, state_d;
    logic [NCORES-1:0] rvalid_q, rvalid_d;
    logic [NCORES-1:0] req_eff, gnt_raw;
    logic [PTRW-1:0]   win;
    logic              gnt_any, locked_hold;
    int                idx;

    // While a lock is held only its owner may compete for the memory.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        locked_hold = (state_q == ST_LOCKED) && lock[owner_q];
        req_eff     = req;
        if (locked_hold)
            req_eff = req & (NCORES'(1) << owner_q);
        gnt_any = 1'b0;
        win     = '0;
        idx     = 0;
        for (int k = 0; k < NCORES; k++) begin
            idx = (int'(ptr_q) + k) % NCORES;
            if (!gnt_any && req_eff[idx]) begin
                gnt_any = 1'b1;
                win     = PTRW'(idx);
            end
        end
        gnt_raw = gnt_any ? (NCORES'(1) << win) : '0;
    end

    always_comb begin
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        state_d  = state_q;
        rvalid_d = gnt_raw & ~we;
        // The pointer is frozen for the whole locked sequence.
        if (gnt_any && !locked_hold)
            ptr_d = (win == PTRW'(NCORES - 1)) ? '0 : win + PTRW'(1);
`ifdef ARB_LOCK_EN
        // Releasing the lock re-arbitrates in the same cycle, which may lock again.
        if (!locked_hold) begin
            if (gnt_any && lock[win]) begin
                state_d = ST_LOCKED;
                owner_d = win;
            end else begin
                state_d = ST_IDLE;
            end
        end
`else
        state_d = ST_IDLE;
`endif
    end

    // NOTE: state flops use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q    <= '0;
            owner_q  <= '0;
            state_q  <= ST_IDLE;
            rvalid_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign gnt        = rst ? gnt_raw : '0;
    assign mem_wr     = rst & gnt_any & we[win];
    assign mem_addr_w = (rst && gnt_any) ? addr[win*MDATAW +: MDATAW] : '0;
    assign mem_addr_r = mem_addr_w;
    assign mem_wdata  = (rst && gnt_any) ? wdata[win*NUBITS +: NUBITS] : '0;
    assign rvalid     = rvalid_q;
    assign rdata      = mem_rdata;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Self-checking bench for shared_mem_arbiter: directed steps followed by random traffic
// checked against a per-cycle behavioural model; lock steps only when ARB_LOCK_EN is defined.
module tb_shared_mem_arbiter;
    localparam int NCORES = 2;
    localparam int MDATAW = 6;
    localparam int NUBITS = 16;
    localparam int DEPTH  = 1 << MDATAW;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [NCORES-1:0]        req = '0, we = '0, lock = '0;
    logic [NCORES*MDATAW-1:0] addr = '0;
    logic [NCORES*NUBITS-1:0] wdata = '0;
    logic [NCORES-1:0]        gnt, rvalid;
    logic [NUBITS-1:0]        rdata, mem_wdata, mem_rdata;
    logic                     mem_wr;
    logic [MDATAW-1:0]        mem_addr_w, mem_addr_r;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    shared_mem_arbiter #(.NCORES(NCORES), .MDATAW(MDATAW), .NUBITS(NUBITS)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .lock(lock),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_wr(mem_wr), .mem_addr_w(mem_addr_w),
        .mem_addr_r(mem_addr_r), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // mem_data stand-in: synchronous write, registered read returning old data.
    logic [NUBITS-1:0] mem_arr [DEPTH] = '{default: '0};
    always @(posedge clk) begin
        if (mem_wr) mem_arr[mem_addr_w] <= mem_wdata;
        mem_rdata <= mem_arr[mem_addr_r];
    end

    // Reference model state.
    int                m_ptr = 0;
    int                m_owner = -1;
    logic [NCORES-1:0] m_rv = '0;
    logic [NUBITS-1:0] m_rd = '0;
    logic [NUBITS-1:0] shadow [DEPTH] = '{default: '0};

    logic [NCORES-1:0] obs_gnt, obs_rvalid;
    logic [NUBITS-1:0] obs_rdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                         input int a0, input int a1, input logic [15:0] d0, input logic [15:0] d1);
        req   = r;
        we    = w;
        lock  = l;
        addr  = {MDATAW'(a1), MDATAW'(a0)};
        wdata = {d1, d0};
    endtask

    // One clock cycle: check outputs mid-cycle against the model, then advance the model.
    task automatic run_cycle(input string tag);
        int                win;
        int                c;
        int                a;
        bit                held;
        logic [NCORES-1:0] e_gnt;
        logic [MDATAW-1:0] e_addr;
        logic [NUBITS-1:0] e_wd;
        logic              e_wr;
        @(negedge clk);
        if (!rst) begin
            m_ptr   = 0;
            m_owner = -1;
            m_rv    = '0;
        end
        held = 1'b0;
`ifdef ARB_LOCK_EN
        held = (m_owner >= 0) && lock[m_owner];
`endif
        win = -1;
        if (rst) begin
            for (int k = 0; k < NCORES; k++) begin
                c = (m_ptr + k) % NCORES;
                if (win < 0 && req[c] && (!held || c == m_owner)) win = c;
            end
        end
        e_gnt  = (win >= 0) ? NCORES'(1 << win) : '0;
        e_wr   = (win >= 0) ? we[win] : 1'b0;
        e_addr = (win >= 0) ? addr[win*MDATAW +: MDATAW] : '0;
        e_wd   = (win >= 0) ? wdata[win*NUBITS +: NUBITS] : '0;
        check({tag, ".gnt"}, gnt, e_gnt);
        check({tag, ".mem_wr"}, mem_wr, e_wr);
        check({tag, ".mem_addr_w"}, mem_addr_w, e_addr);
        check({tag, ".mem_addr_r"}, mem_addr_r, e_addr);
        check({tag, ".mem_wdata"}, mem_wdata, e_wd);
        check({tag, ".rvalid"}, rvalid, m_rv);
        if (m_rv != '0) check({tag, ".rdata"}, rdata, m_rd);
        obs_gnt    = gnt;
        obs_rvalid = rvalid;
        obs_rdata  = rdata;
        @(posedge clk);
        if (rst) begin
            m_rv = '0;
            if (win >= 0) begin
                a = int'(addr[win*MDATAW +: MDATAW]);
                if (we[win]) begin
                    shadow[a] = wdata[win*NUBITS +: NUBITS];
                end else begin
                    m_rv = NCORES'(1 << win);
                    m_rd = shadow[a];
                end
                if (!held) m_ptr = (win + 1) % NCORES;
            end
`ifdef ARB_LOCK_EN
            if (!held) m_owner = (win >= 0 && lock[win]) ? win : -1;
`endif
        end
        #1;
    endtask

    initial begin
        // Reset holds everything quiet even with both cores requesting.
        drive(2'b11, 2'b00, 2'b00, 0, 1, 16'h0, 16'h0);
        #2;
        run_cycle("reset");
        check("reset.gnt_lit", obs_gnt, 2'b00);
        check("reset.rvalid_lit", obs_rvalid, 2'b00);
        rst = 1'b1;
        run_cycle("first");
        check("first.gnt_lit", obs_gnt, 2'b01);

        // Write then read back the same word.
        drive(2'b01, 2'b01, 2'b00, 5, 0, 16'h1234, 16'h0);
        run_cycle("wr5");
        check("wr5.gnt_lit", obs_gnt, 2'b01);
        drive(2'b01, 2'b00, 2'b00, 5, 0, 16'h0, 16'h0);
        run_cycle("rd5");
        drive(2'b00, 2'b00, 2'b00, 0, 0, 16'h0, 16'h0);
        run_cycle("rd5_ret");
        check("rd5.rvalid_lit", obs_rvalid, 2'b01);
        check("rd5.rdata_lit", obs_rdata, 16'h1234);

        // Core1 alone moves the pointer back to core0; idle cycles keep it there.
        drive(2'b10, 2'b00, 2'b00, 0, 5, 16'h0, 16'h0);
        run_cycle("c1_alone");
        check("c1_alone.gnt_lit", obs_gnt, 2'b10);
        drive(2'b00, 2'b00, 2'b00, 0, 0, 16'h0, 16'h0);
        run_cycle("idle1");
        run_cycle("idle2");

        // Fairness: both request reads for six cycles.
        drive(2'b11, 2'b00, 2'b00, 5, 5, 16'h0, 16'h0);
        for (int i = 0; i < 6; i++) begin
            run_cycle("fair");
            check("fair.gnt_lit", obs_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) check("fair.rvalid_lit", obs_rvalid, (i % 2 == 0) ? 2'b10 : 2'b01);
        end

        // Reset in the cycle after a granted read cancels the return.
        run_cycle("pre_rst");
        check("pre_rst.gnt_lit", obs_gnt, 2'b01);
        rst = 1'b0;
        run_cycle("mid_rst");
        check("mid_rst.rvalid_lit", obs_rvalid, 2'b00);
        rst = 1'b1;
        run_cycle("post_rst");
        check("post_rst.gnt_lit", obs_gnt, 2'b01);

`ifdef ARB_LOCK_EN
        // Core1 takes the lock and keeps core0 out for three accesses.
        drive(2'b11, 2'b00, 2'b10, 1, 2, 16'h0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, (i == 1) ? 2'b10 : 2'b00, 2'b10, 1, 2, 16'h0, 16'hbeef);
            run_cycle("locked");
            check("locked.gnt_lit", obs_gnt, 2'b10);
        end
        drive(2'b11, 2'b00, 2'b00, 1, 2, 16'h0, 16'h0);
        run_cycle("unlock");
        check("unlock.gnt_lit", obs_gnt, 2'b01);
`endif

        // Random traffic over a small address window, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            drive(2'($urandom), 2'($urandom), 2'($urandom_range(3, 0) == 0 ? $urandom : 0),
                  int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                  16'($urandom), 16'($urandom));
            rst = ($urandom_range(59, 0) != 0);
            run_cycle("rnd");
        end
        rst = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 0, 0, 16'h0, 16'h0);
        run_cycle("drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
